prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Streams a program into the 9-bit instruction memory read by the fetch unit, then releases the CPU and waits for its `done`.
- Input is a byte stream with a valid/ready handshake.
- Output side drives the instruction-memory write port and the CPU reset line.
- Sits beside `top`: the loader writes the instruction store, the fetch unit reads it.

Parameters:
- IM_DEPTH, 1024, instruction memory depth in words.
- AW, $clog2(IM_DEPTH), instruction address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction memory write enable, one-cycle pulse.
- im_addr  out  AW  instruction memory write address.
- im_wdata  out  9  instruction word.
- cpu_reset  out  1  active-high reset to the CPU; high except in RUN.
- cpu_done  in  1  CPU done/halt.
- busy  out  1  high in any state other than IDLE or ERR.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 length > IM_DEPTH, 2 nonzero pad bits, 3 checksum mismatch.
- instr_count  out  AW+1  number of words written in the last load.

Behaviour:
- Reset (reset==0 at a clk edge) sets these values:
  - state=IDLE.
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_reset=1, busy=0, err=0, err_code=0, instr_count=0.
  - Internal length and checksum registers cleared.
- Reset mid-load aborts immediately. No further im_we pulse is issued, and a byte pair half-received at that point is never written.
- Byte transfer: a byte is accepted only on a cycle where in_valid && in_ready. in_ready is a registered function of state: 1 in LEN_LO, LEN_HI, INS_LO, INS_HI and CHK; 0 otherwise.
- Packet format: len_lo, len_hi, then len pairs {ins_lo, ins_hi}, then one checksum byte.
  - ins_hi[0] is instruction bit 8; ins_hi[7:1] must be 0.
  - Checksum byte must equal the XOR of every preceding byte in the packet.
- FSM states: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, CHK, RUN, ERR.
- FSM transitions:
  - IDLE: start -> LEN_LO. The checksum register, address counter and instr_count are cleared, and err/err_code are cleared.
  - LEN_LO: on accept -> LEN_HI.
  - LEN_HI: on accept, len={len_hi,len_lo}.
    - len > IM_DEPTH -> ERR, err_code=1.
    - len==0 -> CHK.
    - otherwise -> INS_LO.
  - INS_LO: on accept, latch the low byte -> INS_HI.
  - INS_HI: on accept:
    - If pad bits are nonzero -> ERR, err_code=2, and no write occurs.
    - Otherwise, the next cycle has im_we=1, im_wdata={ins_hi[0],ins_lo}, im_addr=current address; the address then increments.
    - When the word just written is word number len -> CHK; otherwise -> INS_LO.
  - CHK: on accept:
    - Match -> RUN; cpu_reset drops to 0 on the following cycle and instr_count=len.
    - Mismatch -> ERR, err_code=3.
  - RUN: cpu_done==1 -> IDLE; cpu_reset returns to 1 the next cycle. cpu_done is ignored outside RUN.
  - ERR: err=1 and cpu_reset=1 are held; only start leaves ERR (-> LEN_LO, clearing err and err_code).
- start is ignored in every state except IDLE and ERR.
- Write latency: im_we fires exactly one cycle after the accepting clk edge of the ins_hi byte. Back-to-back pairs therefore give at most one write every 2 cycles.
- Width rules:
  - The address counter wraps never: len ≤ IM_DEPTH guarantees the last address is IM_DEPTH-1.
  - len==IM_DEPTH is legal.
  - The length comparison is done at 16 bits.
- A stalled stream (in_valid low) holds state indefinitely; there is no timeout.

Decomposition:
- Package loader_pkg holds:
  - typedef enum for the FSM states;
  - localparams ERR_NONE/ERR_LEN/ERR_PAD/ERR_CSUM (2-bit);
  - INSTR_W=9.
- No sub-module; a single module with a registered FSM, address counter and XOR accumulator.

Test Plan:
- Load 3 words 0x1A5,0x003,0x100 (bytes 03 00 A5 01 03 00 00 01 chk=A5) -> im_we pulses at addr 0,1,2 with those data; cpu_reset falls; instr_count=3.
- In RUN, pulse cpu_done -> cpu_reset=1 next cycle, busy=0, state IDLE.
- len=0 (bytes 00 00 00) -> no im_we pulse; RUN entered; instr_count=0.
- Pad violation: ins_hi=0x03 -> no write; err=1, err_code=2; cpu_reset stays 1; a subsequent start and valid packet succeeds with err cleared.
- Bad checksum and len=IM_DEPTH+1 -> err_code=3 and err_code=1 respectively. len=IM_DEPTH -> last write at addr IM_DEPTH-1, then RUN.
- Random in_valid gaps during a 5-word load, then reset low mid-pair -> data identical to the gap-free case; after reset, no further im_we and every output is at its reset value.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, error codes
// and the instruction word width.
package loader_pkg;

    localparam int INSTR_W = 9;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_PAD  = 2'd2;
    localparam logic [1:0] ERR_CSUM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_INS_LO,
        ST_INS_HI,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    // States in which the loader is consuming packet bytes.
    function automatic logic takes_bytes(input state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_INS_LO, ST_INS_HI, ST_CHK};
    endfunction

    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_ERR});
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: byte-stream input, instruction-memory write port, CPU control
// and status. The slave modport is the loader's view; master is its environment.
interface prog_loader_if
    import loader_pkg::*;
#(
    parameter int IM_DEPTH = 1024
) ();
    localparam int AW = $clog2(IM_DEPTH);

    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               im_we;
    logic [AW-1:0]      im_addr;
    logic [INSTR_W-1:0] im_wdata;
    logic               cpu_reset;
    logic               cpu_done;
    logic               busy;
    logic               err;
    logic [1:0]         err_code;
    logic [AW:0]        instr_count;

    modport slave (
        input  start, in_valid, in_data, cpu_done,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset,
               busy, err, err_code, instr_count
    );

    modport master (
        output start, in_valid, in_data, cpu_done,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset,
               busy, err, err_code, instr_count
    );

endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a length-prefixed, XOR-checksummed byte stream into
// 9-bit instruction-memory writes, then releases the CPU until it reports done.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IM_DEPTH = 1024
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    localparam int AW = $clog2(IM_DEPTH);
    localparam int CW = AW + 1;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_im_we;
    logic [AW-1:0]      r_im_addr;
    logic [INSTR_W-1:0] r_im_wdata;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [CW-1:0]      r_instr_count;
    logic [CW-1:0]      r_len;
    logic [CW-1:0]      r_wcount;
    logic [7:0]         r_len_lo;
    logic [7:0]         r_ins_lo;
    logic [7:0]         r_csum;

    state_t             w_next;
    logic               w_accept;
    logic               w_start;
    logic               w_pad_ok;
    logic               w_last_word;
    logic               w_csum_ok;
    logic [15:0]        w_len16;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_accept    = bus.in_valid && r_in_ready;
        w_start     = bus.start && (r_state inside {ST_IDLE, ST_ERR});
        w_len16     = {bus.in_data, r_len_lo};
        w_pad_ok    = (bus.in_data[7:1] == 7'd0);
        w_last_word = ((r_wcount + CW'(1)) == r_len);
        w_csum_ok   = (bus.in_data == r_csum);
        w_next      = r_state;

        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_LEN_LO;
            ST_LEN_LO: if (w_accept) w_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_accept) begin
                    // Compared at full 16 bits so oversized lengths cannot alias.
                    if (w_len16 > 16'(IM_DEPTH))  w_next = ST_ERR;
                    else if (w_len16 == 16'd0)    w_next = ST_CHK;
                    else                          w_next = ST_INS_LO;
                end
            end
            ST_INS_LO: if (w_accept) w_next = ST_INS_HI;
            ST_INS_HI: begin
                if (w_accept) begin
                    if (!w_pad_ok)        w_next = ST_ERR;
                    else if (w_last_word) w_next = ST_CHK;
                    else                  w_next = ST_INS_LO;
                end
            end
            ST_CHK:    if (w_accept) w_next = w_csum_ok ? ST_RUN : ST_ERR;
            ST_RUN:    if (bus.cpu_done) w_next = ST_IDLE;
            ST_ERR:    if (w_start) w_next = ST_LEN_LO;
            default:   w_next = ST_IDLE;
        endcase
    end

    // All outputs are registered from the next state, so they change together
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b0;
            r_im_we       <= 1'b0;
            r_im_addr     <= '0;
            r_im_wdata    <= '0;
            r_cpu_reset   <= 1'b1;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_instr_count <= '0;
            r_len         <= '0;
            r_wcount      <= '0;
            r_len_lo      <= '0;
            r_ins_lo      <= '0;
            r_csum        <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= takes_bytes(w_next);
            r_busy      <= is_busy(w_next);
            r_cpu_reset <= (w_next != ST_RUN);
            r_im_we     <= 1'b0;

            if (w_start) begin
                r_csum        <= '0;
                r_wcount      <= '0;
                r_instr_count <= '0;
                r_err         <= 1'b0;
                r_err_code    <= ERR_NONE;
            end

            if (w_accept && r_state != ST_CHK)
                r_csum <= r_csum ^ bus.in_data;

            if (w_accept) begin
                case (r_state)
                    ST_LEN_LO: r_len_lo <= bus.in_data;
                    ST_LEN_HI: begin
                        if (w_next == ST_ERR) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_LEN;
                        end else begin
                            r_len <= w_len16[CW-1:0];
                        end
                    end
                    ST_INS_LO: r_ins_lo <= bus.in_data;
                    ST_INS_HI: begin
                        if (!w_pad_ok) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_PAD;
                        end else begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= r_wcount[AW-1:0];
                            r_im_wdata <= {bus.in_data[0], r_ins_lo};
                            r_wcount   <= r_wcount + CW'(1);
                        end
                    end
                    ST_CHK: begin
                        if (w_csum_ok) begin
                            r_instr_count <= r_len;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.im_we       = r_im_we;
    assign bus.im_addr     = r_im_addr;
    assign bus.im_wdata    = r_im_wdata;
    assign bus.cpu_reset   = r_cpu_reset;
    assign bus.busy        = r_busy;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a packet-level model predicts every
// instruction write and the final load outcome; a monitor checks each write.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int IM_DEPTH = 1024;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_loader_if #(.IM_DEPTH(IM_DEPTH)) bus ();
    prog_loader #(.IM_DEPTH(IM_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int  n_tests    = 0;
    int  n_fail     = 0;
    int  cyc        = 0;
    int  hi_acc_cyc = -100;
    bit  mon_on     = 1'b0;
    wr_t exp_q[$];
    wr_t mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- packet-level model ----------------
    function automatic int pkt_len(input byte_q_t p);
        return int'({p[1], p[0]});
    endfunction

    function automatic logic [7:0] model_csum(input byte_q_t p, input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ p[i];
        return x;
    endfunction

    // Queue a write for every complete, well-padded pair present in p.
    task automatic model_writes(input byte_q_t p);
        int len = pkt_len(p);
        if (len > IM_DEPTH) return;
        for (int i = 0; i < len; i++) begin
            if (3 + 2 * i >= p.size()) break;
            if (p[3 + 2 * i][7:1] != 7'd0) break;
            exp_q.push_back('{addr: i, data: int'({p[3 + 2 * i][0], p[2 + 2 * i]})});
        end
    endtask

    task automatic model_outcome(input byte_q_t p, output int code, output int count);
        int len = pkt_len(p);
        count = 0;
        if (len > IM_DEPTH) begin
            code = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (p[3 + 2 * i][7:1] != 7'd0) begin
                code = 2;
                return;
            end
        end
        code = (p[2 + 2 * len] == model_csum(p, 2 + 2 * len)) ? 0 : 3;
        if (code == 0) count = len;
    endtask

    task automatic build(input int words[$], input bit bad_chk, output byte_q_t p);
        int         len = words.size();
        logic [7:0] c;
        p = {};
        p.push_back(len[7:0]);
        p.push_back(len[15:8]);
        foreach (words[i]) begin
            p.push_back(words[i][7:0]);
            p.push_back({7'd0, words[i][8]});
        end
        c = model_csum(p, p.size());
        p.push_back(bad_chk ? ~c : c);
    endtask

    // ---------------- write monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && bus.im_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_im_we: write at addr 0x%0h data 0x%0h, none expected",
                             bus.im_addr, bus.im_wdata);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("im_addr", 32'(bus.im_addr), mon_w.addr);
                    check("im_wdata", 32'(bus.im_wdata), mon_w.data);
                    check("im_we_latency_cycle", cyc, hi_acc_cyc);
                end
            end
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_hi);
        bit acc = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (acc && is_hi) hi_acc_cyc = cyc;
        bus.in_valid = 1'b0;
        if (!acc) check("in_ready_timeout", 32'(acc), 1);
    endtask

    task automatic send_packet(input byte_q_t p, input int max_gap, input bit noise);
        int len = pkt_len(p);
        for (int i = 0; i < p.size(); i++) begin
            bit is_hi = (i >= 2) && (i < 2 + 2 * len) && ((i - 2) % 2 == 1);
            int gap   = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.start    = noise && (i == 4);
            bus.cpu_done = noise && (i == 5);
            send_byte(p[i], gap, is_hi);
            bus.start    = 1'b0;
            bus.cpu_done = 1'b0;
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("start_in_ready", 32'(bus.in_ready), 1);
        check("start_busy", 32'(bus.busy), 1);
        check("start_err_cleared", 32'(bus.err), 0);
        check("start_cpu_reset", 32'(bus.cpu_reset), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outcome(input byte_q_t p);
        int code, count;
        model_outcome(p, code, count);
        @(negedge clk);
        check("out_err_code", 32'(bus.err_code), code);
        check("out_err", 32'(bus.err), (code != 0) ? 1 : 0);
        check("out_cpu_reset", 32'(bus.cpu_reset), (code != 0) ? 1 : 0);
        check("out_busy", 32'(bus.busy), (code != 0) ? 0 : 1);
        check("out_in_ready", 32'(bus.in_ready), 0);
        if (code == 0) check("out_instr_count", 32'(bus.instr_count), count);
        @(posedge clk);
        #1;
    endtask

    task automatic do_done();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("run_holds_cpu_reset_low", 32'(bus.cpu_reset), 0);
        @(posedge clk);
        #1;
        bus.cpu_done = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_done = 1'b0;
        @(negedge clk);
        check("done_cpu_reset", 32'(bus.cpu_reset), 1);
        check("done_busy", 32'(bus.busy), 0);
        check("done_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_im_we"}, 32'(bus.im_we), 0);
        check({tag, "_im_addr"}, 32'(bus.im_addr), 0);
        check({tag, "_im_wdata"}, 32'(bus.im_wdata), 0);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_err_code"}, 32'(bus.err_code), 0);
        check({tag, "_instr_count"}, 32'(bus.instr_count), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        byte_q_t p;
        int      w[$];

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.cpu_done = 1'b0;
        reset        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset  = 1'b1;
        mon_on = 1'b1;

        // Three-word load with hand-computed bytes; pins the model.
        p = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 8'h01, 8'hA5};
        check("model_csum_pin", 32'(model_csum(p, 8)), 32'h0A5);
        model_writes(p);
        check("model_nwrites_pin", exp_q.size(), 3);
        check("model_w0_pin", exp_q[0].data, 32'h1A5);
        check("model_w1_pin", exp_q[1].data, 32'h003);
        check("model_w2_addr_pin", exp_q[2].addr, 2);
        check("model_w2_pin", exp_q[2].data, 32'h100);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("t1_writes_drained", exp_q.size(), 0);
        check("t1_instr_count_lit", 32'(bus.instr_count), 3);
        do_done();

        // Empty program.
        p = '{8'h00, 8'h00, 8'h00};
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("len0_instr_count_lit", 32'(bus.instr_count), 0);
        do_done();

        // Pad violation, then a clean reload out of ERR.
        p = '{8'h01, 8'h00, 8'h55, 8'h03};
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("pad_err_code_lit", 32'(bus.err_code), 2);
        bus.cpu_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_done = 1'b0;
        @(negedge clk);
        check("err_sticky", 32'(bus.err), 1);
        check("err_cpu_reset_held", 32'(bus.cpu_reset), 1);
        @(posedge clk);
        #1;
        p = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'h30};
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("reload_err_cleared", 32'(bus.err), 0);
        do_done();

        // Bad checksum, then oversize length.
        p = '{8'h01, 8'h00, 8'h77, 8'h00, 8'h00};
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("csum_err_code_lit", 32'(bus.err_code), 3);
        p = '{8'h01, 8'h04};
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("len_err_code_lit", 32'(bus.err_code), 1);

        // Full-depth program.
        w = {};
        for (int i = 0; i < IM_DEPTH; i++) w.push_back((i * 37 + 5) & 9'h1FF);
        build(w, 1'b0, p);
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b0);
        expect_outcome(p);
        check("full_instr_count_lit", 32'(bus.instr_count), 1024);
        check("full_last_addr_lit", 32'(bus.im_addr), 1023);
        do_done();

        // Five words gap-free with stray start/cpu_done, then with random gaps and a mid-pair reset.
        w = '{9'h0FF, 9'h100, 9'h1FF, 9'h000, 9'h055};
        build(w, 1'b0, p);
        model_writes(p);
        do_start();
        send_packet(p, 0, 1'b1);
        expect_outcome(p);
        do_done();
        p = p[0:8];
        model_writes(p);
        do_start();
        send_packet(p, 3, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_reset_vals("midrst");
        repeat (20) @(posedge clk);
        #1;
        check("midrst_writes_drained", exp_q.size(), 0);
        check("midrst_idle_busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
